// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sizes, state encoding and decoder control-bit positions for the fetch front end
package fetch_pkg;
    localparam int FETCH_BYTES  = 4;
    localparam int QUEUE_BYTES  = 16;
    localparam int WINDOW_BYTES = 5;

    typedef enum logic {ST_RUN, ST_HALT} fetch_state_t;

    localparam int CTRL_HALT    = 0;
    localparam int CTRL_JMP     = 1;
    localparam int CTRL_WE      = 2;
    localparam int CTRL_READ2   = 3;
    localparam int CTRL_READ1   = 4;
    localparam int CTRL_OP      = 5;
    localparam int CTRL_SRC2MUX = 6;
endpackage

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: shift-compacting byte queue with 4-byte push, 0..5 byte pop, flush and a 5-byte head window
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = QUEUE_BYTES,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [8*FETCH_BYTES-1:0]  push_data,
    input  logic [2:0]                pop,
    input  logic                      flush,
    output logic [CW-1:0]             count,
    output logic [CW-1:0]             count_next,
    output logic [8*WINDOW_BYTES-1:0] head
);
    localparam int DW = 8 * DEPTH;

    logic [DW-1:0] data;
    logic [DW-1:0] kept;
    logic [DW-1:0] data_next;
    logic [CW-1:0] surv;

    // bytes at index >= count are always zero, so a plain shift compacts without masking
    assign surv       = count - CW'(pop);
    assign kept       = data >> {pop, 3'b000};
    assign data_next  = flush ? '0 : push ? kept | (DW'(push_data) << {surv, 3'b000}) : kept;
    assign count_next = flush ? '0 : surv + (push ? CW'(FETCH_BYTES) : CW'(0));
    assign head       = data[8*WINDOW_BYTES-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            count <= '0;
        end else begin
            data  <= data_next;
            count <= count_next;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches imem words into a byte queue and sequences decode, jump redirect and halt
module fetch_sequencer #(
    parameter int          FETCH_BYTES = fetch_pkg::FETCH_BYTES,
    parameter int          QUEUE_BYTES = fetch_pkg::QUEUE_BYTES,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [39:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_valid,
    input  logic [7:0]  dec_length,
    input  logic [31:0] dec_imm,
    input  logic        dec_is_jmp,
    input  logic        dec_is_halt,
    input  logic        dec_ready,
    output logic        halted
);
    import fetch_pkg::*;

    localparam int CW = $clog2(QUEUE_BYTES + 1);

    fetch_state_t state;
    fetch_state_t state_n;
    logic [31:0]  pc;
    logic [31:0]  pc_n;
    logic [31:0]  fetch_addr;
    logic [31:0]  fetch_addr_n;
    logic [31:0]  target;
    logic         outstanding;
    logic         outstanding_n;
    logic         drop;
    logic         drop_n;
    logic         req_q;
    logic         req_n;
    logic         retire;
    logic         jmp_retire;
    logic         halt_retire;
    logic         req_fire;
    logic         rsp_take;
    logic         push;
    logic [2:0]   pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    fetch_byte_queue #(.DEPTH(QUEUE_BYTES)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (imem_rsp_data),
        .pop       (pop),
        .flush     (jmp_retire),
        .count     (count),
        .count_next(count_next),
        .head      (dec_instr)
    );

    assign req_fire    = req_q && imem_req_ready;
    assign rsp_take    = imem_rsp_valid && outstanding;
    assign dec_valid   = state == ST_RUN && count != '0 && 8'(count) >= dec_length;
    assign retire      = dec_valid && dec_ready;
    assign halt_retire = retire && dec_is_halt;
    assign jmp_retire  = retire && dec_is_jmp && !dec_is_halt;
    assign target      = pc + 32'(dec_length) + dec_imm;
    assign pop         = halt_retire ? 3'd1 : retire ? dec_length[2:0] : 3'd0;
    assign push        = rsp_take && !drop && state == ST_RUN;

    assign state_n       = halt_retire ? ST_HALT : state;
    assign pc_n          = halt_retire ? pc + 32'd1 : jmp_retire ? target : retire ? pc + 32'(dec_length) : pc;
    assign fetch_addr_n  = jmp_retire ? target : req_fire ? fetch_addr + 32'(FETCH_BYTES) : fetch_addr;
    assign outstanding_n = req_fire || (outstanding && !imem_rsp_valid);
    // a request still in flight (or launched this very cycle) at a jump carries stale bytes
    assign drop_n        = jmp_retire ? (outstanding && !imem_rsp_valid) || req_fire : drop && !rsp_take;
    // request valid is registered from next-state values so it is low throughout reset
    assign req_n         = state_n == ST_RUN && !outstanding_n && int'(count_next) + FETCH_BYTES <= QUEUE_BYTES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            fetch_addr  <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            req_q       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fetch_addr  <= fetch_addr_n;
            outstanding <= outstanding_n;
            drop        <= drop_n;
            req_q       <= req_n;
            halted      <= state_n == ST_HALT;
        end
    end

    assign imem_req_valid = req_q;
    assign imem_req_addr  = fetch_addr;
    assign dec_pc         = pc;

    assert property (@(posedge clk) disable iff (!rst_n) imem_req_valid |-> !outstanding);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench with a byte-image memory model and a tiny reference decoder
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [39:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_valid;
    logic [7:0]  dec_length;
    logic [31:0] dec_imm;
    logic        dec_is_jmp;
    logic        dec_is_halt;
    logic        dec_ready;
    logic        halted;

    logic [7:0]  mem [256];
    logic        hold;
    logic        clr;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] last_req_addr;
    int          req_count;
    int          checks = 0;
    int          failures = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_valid     (dec_valid),
        .dec_length    (dec_length),
        .dec_imm       (dec_imm),
        .dec_is_jmp    (dec_is_jmp),
        .dec_is_halt   (dec_is_halt),
        .dec_ready     (dec_ready),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        dec_is_jmp  = dec_instr[7:0] == 8'hE9;
        dec_is_halt = dec_instr[7:0] == 8'hF4;
        dec_length  = (dec_instr[7:0] == 8'hB8 || dec_is_jmp) ? 8'd5 : dec_instr[7:0] == 8'h01 ? 8'd2 : 8'd1;
        dec_imm     = dec_length == 8'd5 ? dec_instr[39:8] : 32'd0;
    end

    // memory acts 2ns after each rising edge: answers one cycle after the handshake unless held
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend           = 1'b0;
        pend_addr      = '0;
        last_req_addr  = '1;
        req_count      = 0;
        forever begin
            @(posedge clk);
            #2;
            imem_rsp_valid = 1'b0;
            if (clr) pend = 1'b0;
            if (pend && !hold) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = {mem[8'(pend_addr + 3)], mem[8'(pend_addr + 2)], mem[8'(pend_addr + 1)], mem[pend_addr[7:0]]};
                pend           = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend          = 1'b1;
                pend_addr     = imem_req_addr;
                last_req_addr = imem_req_addr;
                req_count++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clr       = 1'b1;
        hold      = 1'b0;
        dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        clr   = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 50 && !dec_valid; n++) @(negedge clk);
        check(tag, 64'(dec_valid), 64'd1);
    endtask

    task automatic retire_one();
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
    endtask

    initial begin
        int          seen;
        int          rc0;
        logic [31:0] exp_pc;
        imem_req_ready = 1'b1;
        hold           = 1'b0;
        clr            = 1'b1;
        dec_ready      = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]} = 32'h345678B8;
        {mem[7], mem[6], mem[5], mem[4]} = 32'h0000F412;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_dec_instr", 64'(dec_instr), 64'd0);
        check("rst_dec_pc", 64'(dec_pc), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        clr   = 1'b0;
        rst_n = 1'b1;

        wait_valid("t1_valid");
        check("t1_instr", 64'(dec_instr), 64'h12_3456_78B8);
        check("t1_pc", 64'(dec_pc), 64'd0);
        retire_one();
        check("t1_pc5", 64'(dec_pc), 64'd5);
        check("t1_f4", 64'(dec_instr[7:0]), 64'hF4);
        check("t1_not_halted", 64'(halted), 64'd0);
        retire_one();
        check("t1_halted", 64'(halted), 64'd1);
        check("t1_halt_dvalid", 64'(dec_valid), 64'd0);
        check("t1_halt_pc", 64'(dec_pc), 64'd6);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen += int'(imem_req_valid) + int'(dec_valid);
        end
        check("t1_halt_quiet", 64'(seen), 64'd0);
        check("t1_halt_sticky", 64'(halted), 64'd1);

        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'hE9;
        mem[1] = 8'h10;
        {mem[11], mem[10], mem[9], mem[8]} = 32'hF4F4F4F4;
        for (int i = 0; i < 5; i++) mem[21 + i] = 8'(8'h90 + i);
        do_reset();
        check("t2_rst_halted", 64'(halted), 64'd0);
        wait_valid("t2_valid");
        hold = 1'b1;
        for (int n = 0; n < 10 && !pend; n++) @(negedge clk);
        check("t2_req8", 64'(pend_addr), 64'h8);
        @(negedge clk);
        check("t2_jmp_instr", 64'(dec_instr), 64'h00_0000_10E9);
        rc0 = req_count;
        retire_one();
        check("t2_jmp_pc", 64'(dec_pc), 64'h15);
        check("t2_flushed", 64'(dec_valid), 64'd0);
        hold = 1'b0;
        for (int n = 0; n < 20 && req_count == rc0; n++) @(negedge clk);
        check("t2_redirect_addr", 64'(last_req_addr), 64'h15);
        wait_valid("t2_valid2");
        check("t2_target_pc", 64'(dec_pc), 64'h15);
        check("t2_target_bytes", 64'(dec_instr[31:0]), 64'h9392_9190);

        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h90 + i);
        do_reset();
        rc0 = req_count;
        repeat (30) @(negedge clk);
        check("t3_fill_reqs", 64'(req_count - rc0), 64'd4);
        check("t3_instr_a", 64'(dec_instr), 64'h94_9392_9190);
        check("t3_pc_a", 64'(dec_pc), 64'd0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(imem_req_valid);
        end
        check("t3_full_noreq", 64'(seen), 64'd0);
        check("t3_instr_b", 64'(dec_instr), 64'h94_9392_9190);
        check("t3_pc_b", 64'(dec_pc), 64'd0);
        dec_ready = 1'b1;
        repeat (3) @(negedge clk);
        dec_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_count13_reqs", 64'(req_count - rc0), 64'd4);
        check("t3_pc3", 64'(dec_pc), 64'd3);
        check("t3_instr3", 64'(dec_instr), 64'h97_9695_9493);
        retire_one();
        repeat (2) @(negedge clk);
        check("t3_count12_reqs", 64'(req_count - rc0), 64'd5);

        for (int i = 0; i < 128; i++) begin
            mem[2*i]     = 8'h01;
            mem[2*i + 1] = 8'(i);
        end
        do_reset();
        dec_ready = 1'b1;
        exp_pc = 32'd0;
        for (int n = 0; n < 400 && exp_pc < 32'd64; n++) begin
            @(negedge clk);
            if (dec_valid) begin
                check("t4_stream", 64'({dec_pc, dec_instr[15:0]}), 64'({exp_pc, mem[8'(exp_pc + 1)], mem[exp_pc[7:0]]}));
                exp_pc += 32'd2;
            end
        end
        dec_ready = 1'b0;
        check("t4_done", 64'(exp_pc), 64'd64);

        do_reset();
        wait_valid("t5_valid");
        hold = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("t5_rst_dec_valid", 64'(dec_valid), 64'd0);
        check("t5_rst_dec_instr", 64'(dec_instr), 64'd0);
        check("t5_rst_dec_pc", 64'(dec_pc), 64'd0);
        check("t5_rst_halted", 64'(halted), 64'd0);
        hold = 1'b0;
        rc0 = req_count;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_late_ignored", 64'(dec_valid), 64'd0);
        check("t5_late_instr", 64'(dec_instr), 64'd0);
        check("t5_new_req", 64'({32'(req_count - rc0), last_req_addr}), {32'd1, 32'd0});
        wait_valid("t5_valid2");
        check("t5_pc", 64'(dec_pc), 64'd0);
        check("t5_bytes", 64'(dec_instr[15:0]), 64'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end controller that feeds the combinational decode stage. It fetches 32-bit little-endian words from instruction memory into a byte queue and presents a 40-bit instruction window plus PC to the decoder. Each decoded instruction is retired by popping the decoder's reported length, and the block updates the PC. It handles JMP redirect (flush plus refetch) and HALT (stop fetching, freeze).

Parameters:
FETCH_BYTES, 4, bytes returned per imem response (fixed 4; the port width depends on it)
QUEUE_BYTES, 16, byte-queue capacity; must be >= 5 + FETCH_BYTES
RESET_PC, 32'h0000_0000, PC and first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  byte address of the fetch (arbitrary alignment)
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid (at least 1 cycle after request handshake)
imem_rsp_data  in  32  bytes at addr..addr+3, byte 0 in [7:0]
dec_instr  out  40  window: queue bytes 0..4, byte 0 in [7:0]; bytes at index >= count are 0
dec_pc  out  32  PC of byte 0 of the window
dec_valid  out  1  window holds a complete instruction
dec_length  in  8  length from decoder (combinational on dec_instr)
dec_imm  in  32  immediate from decoder
dec_is_jmp  in  1  ctrl[1] from decoder
dec_is_halt  in  1  ctrl[0] from decoder
dec_ready  in  1  downstream consumes the instruction this cycle
halted  out  1  HALT retired

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, fetch_addr=RESET_PC, count=0, outstanding=0, drop=0, state=RUN. Outputs: imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=RESET_PC, halted=0. Deassertion mid-fetch: any later response is ignored until the block issues a new request.
- States: RUN and HALT only. HALT is terminal until reset.
- Fetch request: imem_req_valid = RUN && !outstanding && (count + FETCH_BYTES <= QUEUE_BYTES). Use count before the pop.
- On request handshake: outstanding=1 and fetch_addr += 4.
- At most one request is outstanding.
- On imem_rsp_valid with outstanding=1:
  - drop=0: append 4 bytes at queue index count-pop.
  - drop=1: discard the data and clear drop.
  - In both cases outstanding=0.
- A response with outstanding=0 is ignored.
- dec_valid = RUN && count != 0 && count >= dec_length. Unknown opcodes report length 1, so they always make progress.
- Retire (dec_valid && dec_ready): pop dec_length bytes (shift down) and set pc = pc + dec_length (mod 2^32).
- Pop and push may happen in the same cycle: count_next = count - pop + push, and pushed bytes land after the surviving bytes.
- JMP retire: target = pc + dec_length + dec_imm (32-bit wrap).
  - Set pc=target and fetch_addr=target, and count=0.
  - Any push in the same cycle is discarded.
  - If a request is outstanding and its response has not arrived this cycle, set drop=1.
  - A request may issue from the cycle after the JMP retires.
- HALT retire: pop 1, pc += 1, state=HALT, halted=1 from the next cycle.
  - In HALT: imem_req_valid=0, dec_valid=0, and the in-flight response is absorbed and discarded.
- dec_pc and dec_instr are registered views of the queue head. They are stable while dec_valid && !dec_ready.
- No overflow is possible by construction. Assertion: count never exceeds QUEUE_BYTES.

Decomposition:
- Shared package (fetch_pkg):
  - FETCH_BYTES and QUEUE_BYTES defaults
  - WINDOW_BYTES=5
  - state enum {RUN, HALT}
  - ctrl bit positions: HALT=0, JMP=1, WE=2, READ2=3, READ1=4, OP=5, SRC2MUX=6
- One sub-module, fetch_byte_queue. It is a shift-compacting byte queue with:
  - push of 4 bytes
  - pop of 0..5 bytes
  - flush
  - count output
  - 5-byte head window
- fetch_sequencer holds the PC, the fetch FSM, and the redirect/drop logic.

Test Plan:
- Reset, then memory returns B8 78 56 34 | 12 F4 00 00 at addr 0 and 4 -> first dec_valid with dec_instr=40'h12_3456_78B8, dec_pc=0. Retire len 5 -> dec_pc=5, dec_instr[7:0]=F4.
- Retire F4 at pc 5 -> halted=1 next cycle; imem_req_valid stays 0 for 20 cycles; dec_valid=0.
- E9 10 00 00 00 at pc 0 with dec_imm=16, retired while a request to addr 8 is outstanding -> next request addr=0x15. The stale addr-8 response is dropped, and the first post-jump dec_pc=0x15.
- dec_ready=0 for 10 cycles with the queue filling -> at most 16 bytes held, requests stop at count>12, and dec_instr/dec_pc stay stable.
- Stream of 01 C8 (len 2) with a response arriving on the same cycle as each retire -> PCs 0,2,4,...; no byte lost or duplicated (scoreboard against a memory image).
- rst_n pulsed low mid-response -> all outputs return to reset values immediately, and the late response is ignored.
